// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the microwave countdown timer.
// State encoding, BCD digit limits and the digit-validity helper.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [3:0]  BCD_MAX      = 4'd9;
  localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
  localparam int          NUM_DIGITS   = 3;
  // Digit vector {min_ones, sec_tens, sec_ones} reading 0:01.
  localparam logic [11:0] ONE_SEC      = 12'h001;

  function automatic logic bcd_ok(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Keypad/display bundle between the keypad encoder side and the timer.
// master = the side driving keypad strobes and enable; slave = the timer.
interface countdown_timer_if;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;
  logic       enable;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic       zero;
  logic       done;
  logic       running;

  modport master (
    output D, loadn, pgt_1Hz, enable,
    input  sec_ones, sec_tens, min_ones, zero, done, running
  );

  modport slave (
    input  D, loadn, pgt_1Hz, enable,
    output sec_ones, sec_tens, min_ones, zero, done, running
  );
endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit register: parallel load or decrement with wrap to max_val.
// borrow_out fires when a decrement wraps this digit, feeding the next digit.
module bcd_down_digit (
  input  logic       clk,
  input  logic       clear,
  input  logic       load_en,
  input  logic [3:0] load_val,
  input  logic [3:0] max_val,
  input  logic       dec_en,
  output logic [3:0] digit,
  output logic       borrow_out
);

  always_ff @(posedge clk) begin
    if (clear)        digit <= 4'd0;
    else if (load_en) digit <= load_val;
    else if (dec_en)  digit <= (digit == 4'd0) ? max_val : digit - 4'd1;
  end

  assign borrow_out = dec_en & (digit == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// Microwave countdown timer: keypad digit entry by left shift, then a BCD
// m:ss countdown on 1 Hz ticks with a one-cycle done pulse at 0:00.
module countdown_timer
  import countdown_timer_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  countdown_timer_if.slave  bus
);

  logic loadn_s, loadn_q, pgt_s, pgt_q;
  logic load_evt, tick_evt;

  // Both stages reset high so no edge is seen right after clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      loadn_s <= 1'b1;
      loadn_q <= 1'b1;
      pgt_s   <= 1'b1;
      pgt_q   <= 1'b1;
    end else begin
      loadn_s <= bus.loadn;
      loadn_q <= loadn_s;
      pgt_s   <= bus.pgt_1Hz;
      pgt_q   <= pgt_s;
    end
  end

  assign load_evt = loadn_q & ~loadn_s;
  assign tick_evt = ~pgt_q & pgt_s;

  state_t state, state_nxt;
  logic   load_en, dec, done_nxt, done_q, zero;

  logic [NUM_DIGITS-1:0][3:0] digits, load_vals;
  logic [NUM_DIGITS:0]        carry;
  localparam logic [NUM_DIGITS-1:0][3:0] DIGIT_MAX = {BCD_MAX, SEC_TENS_MAX, BCD_MAX};

  assign zero = (digits == '0);

  always_ff @(posedge clk) begin
    if (clear) begin
      state  <= LOAD;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    dec       = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      LOAD: begin
        load_en = load_evt & bcd_ok(bus.D);
        if (bus.enable && !zero) state_nxt = RUN;
      end
      RUN: begin
        // Pause wins over a coincident tick.
        if (!bus.enable) state_nxt = LOAD;
        else if (tick_evt && !zero) begin
          dec = 1'b1;
          if (digits == ONE_SEC) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      DONE: if (!bus.enable) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Digit 0 = sec_ones, 1 = sec_tens, 2 = min_ones; load shifts left.
  assign carry[0] = dec;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      if (g == 0) begin : g_in
        assign load_vals[g] = bus.D;
      end else begin : g_in
        assign load_vals[g] = digits[g-1];
      end
      bcd_down_digit u_dig (
        .clk       (clk),
        .clear     (clear),
        .load_en   (load_en),
        .load_val  (load_vals[g]),
        .max_val   (DIGIT_MAX[g]),
        .dec_en    (carry[g]),
        .digit     (digits[g]),
        .borrow_out(carry[g+1])
      );
    end
  endgenerate

  // A borrow out of min_ones would mean going below 0:00, which the FSM blocks.
  logic unused_top_borrow;
  assign unused_top_borrow = carry[NUM_DIGITS];

  assign bus.sec_ones = digits[0];
  assign bus.sec_tens = digits[1];
  assign bus.min_ones = digits[2];
  assign bus.zero     = zero;
  assign bus.done     = done_q;
  assign bus.running  = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues expected display
// snapshots tagged with the sample cycle; a negedge monitor pops and compares.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  countdown_timer_if tif ();

  countdown_timer dut (
    .clk  (clk),
    .clear(clear),
    .bus  (tif)
  );

  typedef struct {
    string name;
    int    at;
    int    mo, st, so, z, r, d;
  } exp_t;

  exp_t exp_q[$];
  int   mcyc      = 0;
  int   n_total   = 0;
  int   n_pass    = 0;
  int   done_seen = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected state after the most recent posedge, sampled at the next negedge.
  task automatic chk(input string name, input int mo, st, so, z, r, d);
    exp_t e;
    e.name = name; e.at = mcyc + 1;
    e.mo = mo; e.st = st; e.so = so; e.z = z; e.r = r; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic strobe(input int d);
    tif.D = 4'(d);
    tif.loadn = 1'b0;
    step(3);
    tif.loadn = 1'b1;
    step(3);
  endtask

  task automatic tick();
    tif.pgt_1Hz = 1'b1;
    step(3);
    tif.pgt_1Hz = 1'b0;
    step(3);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      mcyc++;
      if (tif.done === 1'b1) done_seen++;
      while (exp_q.size() > 0 && exp_q[0].at <= mcyc) begin
        e = exp_q.pop_front();
        n_total++;
        if (tif.min_ones === 4'(e.mo) && tif.sec_tens === 4'(e.st) &&
            tif.sec_ones === 4'(e.so) && tif.zero === 1'(e.z) &&
            tif.running === 1'(e.r) && tif.done === 1'(e.d))
          n_pass++;
        else
          $display("FAIL %s: got %0d:%0d%0d zero=%b run=%b done=%b, want %0d:%0d%0d zero=%0d run=%0d done=%0d",
                   e.name, tif.min_ones, tif.sec_tens, tif.sec_ones, tif.zero, tif.running,
                   tif.done, e.mo, e.st, e.so, e.z, e.r, e.d);
      end
    end
  end

  initial begin
    clear = 1'b1;
    tif.D = 4'd0; tif.loadn = 1'b1; tif.pgt_1Hz = 1'b0; tif.enable = 1'b0;
    step(3);
    clear = 1'b0;
    chk("reset", 0,0,0, 1,0,0);

    // Entry with latency probe on the first strobe
    tif.D = 4'd1; tif.loadn = 1'b0;
    step(1); chk("lat_1clk", 0,0,0, 1,0,0);
    step(1); chk("lat_2clk", 0,0,1, 0,0,0);
    step(1); tif.loadn = 1'b1; step(3);
    strobe(3);  chk("entry_13",  0,1,3, 0,0,0);
    strobe(0);  chk("entry_130", 1,3,0, 0,0,0);
    strobe(12); chk("bad_digit", 1,3,0, 0,0,0);

    // Borrow across both digits, load ignored in RUN
    do_clear; chk("clear_load", 0,0,0, 1,0,0);
    strobe(1); strobe(0); strobe(0); chk("load_100", 1,0,0, 0,0,0);
    tif.enable = 1'b1; step(1); chk("run_100", 1,0,0, 0,1,0);
    tick;       chk("borrow_059",   0,5,9, 0,1,0);
    strobe(3);  chk("run_load_ign", 0,5,9, 0,1,0);
    tif.enable = 1'b0; step(1); chk("pause_059", 0,5,9, 0,0,0);

    do_clear; strobe(1); strobe(0);
    tif.enable = 1'b1; step(1);
    tick; chk("borrow_009", 0,0,9, 0,1,0);
    tif.enable = 1'b0; step(1);

    // Countdown to zero and done pulse
    do_clear; strobe(2); chk("load_002", 0,0,2, 0,0,0);
    tif.enable = 1'b1; step(1);
    tick; chk("cd_001", 0,0,1, 0,1,0);
    tif.pgt_1Hz = 1'b1;
    step(2); chk("cd_000_done", 0,0,0, 1,0,1);
    step(1); chk("done_1cyc",   0,0,0, 1,0,0);
    tif.pgt_1Hz = 1'b0; step(3);
    tick;      chk("tick_at_0",     0,0,0, 1,0,0);
    strobe(5); chk("done_load_ign", 0,0,0, 1,0,0);
    tif.enable = 1'b0; step(1);
    tif.enable = 1'b1; step(2); chk("en_at_zero", 0,0,0, 1,0,0);
    tif.enable = 1'b0; step(1);

    // Pause, extend entry, resume
    do_clear; strobe(4); strobe(5);
    tif.enable = 1'b1; step(1);
    tick; chk("p_044", 0,4,4, 0,1,0);
    tif.enable = 1'b0; step(1);
    repeat (3) tick;
    chk("p_hold", 0,4,4, 0,0,0);
    strobe(7); chk("p_447", 4,4,7, 0,0,0);
    tif.enable = 1'b1; step(1); chk("resume", 4,4,7, 0,1,0);
    tick; chk("r_446", 4,4,6, 0,1,0);
    // enable drops in the cycle tick_evt is live
    tif.pgt_1Hz = 1'b1; step(1);
    tif.enable = 1'b0;  step(1); chk("tick_vs_pause", 4,4,6, 0,0,0);
    tif.pgt_1Hz = 1'b0; step(3);

    // Out-of-range tens digit counts down as written
    do_clear; strobe(7); strobe(5); chk("load_075", 0,7,5, 0,0,0);
    tif.enable = 1'b1; step(1);
    tick; chk("dec_074", 0,7,4, 0,1,0);
    tif.enable = 1'b0; step(1);

    // Clear mid-countdown while a tick edge is in flight
    do_clear; strobe(3); strobe(0);
    tif.enable = 1'b1; step(1);
    tick; chk("r_029", 0,2,9, 0,1,0);
    tif.pgt_1Hz = 1'b1; step(1);
    clear = 1'b1; step(1);
    clear = 1'b0; chk("mid_clear",  0,0,0, 1,0,0);
    step(1);      chk("post_clear", 0,0,0, 1,0,0);
    tif.pgt_1Hz = 1'b0; step(3);
    tif.enable = 1'b0; step(1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    n_total++;
    if (done_seen == 1) n_pass++;
    else $display("FAIL done_count: got %0d cycles, want 1", done_seen);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
- REQ-001 No parameters; all widths are fixed.
- REQ-002 clk  input  1  system clock; all state changes on its rising edge.
- REQ-003 clear  input  1  synchronous, active-high reset.
- REQ-004 D  input  4  BCD digit from the keypad encoder; valid while loadn is low.
- REQ-005 loadn  input  1  active-low digit strobe from the keypad encoder.
- REQ-006 pgt_1Hz  input  1  1 Hz tick level (or single-edge pulse) from the keypad encoder; only its rising edge counts.
- REQ-007 enable  input  1  1 = start or continue the countdown (door closed, start pressed); 0 = stop/pause.
- REQ-008 sec_ones  output  4  seconds units, BCD 0-9.
- REQ-009 sec_tens  output  4  seconds tens, BCD 0-5.
- REQ-010 min_ones  output  4  minutes units, BCD 0-9.
- REQ-011 zero  output  1  high when all three digits are 0.
- REQ-012 done  output  1  one-cycle pulse when the countdown reaches 0:00.
- REQ-013 running  output  1  high in state RUN (drives magnetron/lamp).

Function
- REQ-014 Edge detection: registered copies of loadn and pgt_1Hz; load_evt = prev loadn 1 and current loadn 0; tick_evt = prev pgt_1Hz 0 and current pgt_1Hz 1; each event lasts exactly one clk cycle.
- REQ-015 FSM states: LOAD, RUN, DONE.
- REQ-016 LOAD: on load_evt with D <= 9, shift left in the same edge: min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= D.
- REQ-017 LOAD: on load_evt with D > 9, ignore the digit; the registers are unchanged.
- REQ-018 Shifted-in values are not range-checked against 5; the entry 0:75 is decremented as written (75, 74, ...), and the tens-of-seconds wrap 0->5 applies only on a borrow.
- REQ-019 LOAD -> RUN when enable = 1 and zero = 0; when enable = 1 and zero = 1, stay in LOAD.
- REQ-020 RUN: on tick_evt, decrement by one second in BCD: sec_ones 0 -> 9 with borrow; sec_tens 0 -> 5 with borrow; min_ones decrements on borrow.
- REQ-021 RUN: load_evt is ignored.
- REQ-022 RUN: when a decrement produces 0:00, next state is DONE and done pulses in the cycle the digits become 0.
- REQ-023 RUN -> LOAD when enable = 0 (pause; digits retained; new digits may then be shifted in).
- REQ-024 If enable falls in the same cycle as tick_evt, the decrement is not applied.
- REQ-025 DONE: digits are held at 0; tick_evt and load_evt are ignored; DONE -> LOAD when enable = 0.
- REQ-026 At 0:00 no decrement occurs; there is no wrap below zero.
- REQ-027 Latency: the digit outputs change 1 clk after the raw input edge is sampled, i.e. 2 clk after a loadn or pgt_1Hz transition.
- REQ-028 zero and running are combinational decodes of the registered state/digits; done is registered.

Reset
- REQ-029 While clear = 1 at a clk edge: state = LOAD; sec_ones, sec_tens and min_ones = 0; done = 0; edge-detect registers = 1 (loadn) and 1 (pgt_1Hz), so no false event is generated after reset.
- REQ-030 clear takes priority over all events, including mid-countdown; the outputs read 0:00 with zero = 1 and running = 0 in the cycle after clear.

Structure
- REQ-031 A shared package holds the state encoding (LOAD = 2'b00, RUN = 2'b01, DONE = 2'b10) and the constants BCD_MAX = 9 and SEC_TENS_MAX = 5.
- REQ-032 One sub-module, bcd_down_digit, is instantiated three times.
  - Inputs: load value, max value, decrement enable.
  - Outputs: digit, borrow-out.
  - The instances chain their borrow signals.

Verification
- REQ-033 Entry: clear, then loadn strobes with D = 1, 3, 0 -> 1:30 displayed after the third strobe, zero = 0.
- REQ-034 Countdown: 0:02 loaded, enable = 1, two pgt_1Hz edges -> 0:01, then 0:00; done high exactly 1 cycle; state DONE; a third tick leaves 0:00.
- REQ-035 Borrow: 1:00 running, one tick -> 0:59; 0:10 running, one tick -> 0:09.
- REQ-036 Pause: 0:45 running, enable = 0 after one tick -> 0:44 held across 3 ticks; strobe D = 7 -> 4:47; enable = 1 resumes from 4:47.
- REQ-037 Guards: in LOAD, D = 12 strobed -> no change; in RUN, loadn strobe -> no change; enable = 1 at 0:00 -> stays in LOAD, running = 0.
- REQ-038 Reset mid-run: 0:30 counting, clear = 1 for 1 cycle -> 0:00, LOAD, done = 0, no spurious event on the following cycle.
